// File: rtl/output_history_display.sv
// Result history for the board display: captures CPU results on a load edge into a
// ring buffer and pages backwards through them with a debounced push-button.
module output_history_display #(
    parameter int WIDTH           = 16,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         din,
    input  logic                     step_key,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             load_q;
    logic             cap;
    logic             s1, s2;
    logic             key_stable, ks_q;
    logic             armed;
    logic [1:0]       warm;
    logic [DW-1:0]    deb_cnt;
    logic             step;

    assign cap    = load & ~load_q;
    assign step   = key_stable & ~ks_q & armed;
    assign rd_ptr = wr_ptr - AW'(1) - idx;

    always_ff @(posedge clk) begin
        if (cap)
            mem[wr_ptr] <= din;
    end

    // Synchronizer and debounce filter; the counter only runs while s2 disagrees
    // with the accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            key_stable <= 1'b0;
            ks_q       <= 1'b0;
            deb_cnt    <= '0;
        end else begin
            s1   <= step_key;
            s2   <= s1;
            ks_q <= key_stable;
            if (s2 == key_stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                key_stable <= s2;
                deb_cnt    <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // A key held through reset must be accepted low before any press may step.
    // warm skips the cycles where the synchronizer still holds its reset zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm  <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (warm != 2'd2)
                warm <= warm + 2'd1;
            else if (!s2 && !key_stable)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q <= 1'b0;
            wr_ptr <= '0;
            count  <= '0;
            idx    <= '0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            load_q <= load;
            dout   <= (count == '0) ? '0 : mem[rd_ptr];
            if (cap) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (count != CW'(DEPTH))
                    count <= count + CW'(1);
                idx   <= '0;
                empty <= 1'b0;
            end else if (step && count != '0) begin
                if (CW'(idx) == count - CW'(1))
                    idx <= '0;
                else
                    idx <= idx + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_output_history_display.sv
// Self-checking bench for output_history_display: table-driven directed vectors,
// hand-written timing corner cases, then random ops against a queue-based model.
module tb_output_history_display;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             step_key = 1'b0;
    logic [WIDTH-1:0] dout;
    logic [1:0]       idx;
    logic [2:0]       count;
    logic             empty;

    int checks = 0;
    int errors = 0;

    output_history_display #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .load(load), .din(din), .step_key(step_key),
        .dout(dout), .idx(idx), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;      // 0 = load edge, 1 = key press
        logic [15:0] d;
        int          hold;
        logic [15:0] e_dout;
        int          e_idx;
        int          e_cnt;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ed, input int ei, input int ec);
        chk({tag, ".dout"}, 32'(dout), 32'(ed));
        chk({tag, ".idx"}, 32'(idx), ei);
        chk({tag, ".count"}, 32'(count), ec);
        chk({tag, ".empty"}, 32'(empty), (ec == 0) ? 1 : 0);
    endtask

    // Load held for 'hold' cycles; din changes after the first cycle so a
    // second capture would be visible.
    task automatic do_load(input logic [15:0] d, input int hold);
        din  = d;
        load = 1'b1;
        @(negedge clk);
        din = 16'hDEAD;
        repeat (hold - 1) @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press();
        step_key = 1'b1;
        repeat (10) @(negedge clk);
        step_key = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          q[$];
        int          midx;
        logic [15:0] rd;
        logic [15:0] exp_d;

        tbl[0]  = '{0, 16'h1111, 1,  16'h1111, 0, 1};
        tbl[1]  = '{0, 16'h2222, 1,  16'h2222, 0, 2};
        tbl[2]  = '{0, 16'h3333, 20, 16'h3333, 0, 3};
        tbl[3]  = '{1, 16'h0,    0,  16'h2222, 1, 3};
        tbl[4]  = '{1, 16'h0,    0,  16'h1111, 2, 3};
        tbl[5]  = '{1, 16'h0,    0,  16'h3333, 0, 3};
        tbl[6]  = '{0, 16'h4444, 1,  16'h4444, 0, 4};
        tbl[7]  = '{0, 16'h5555, 2,  16'h5555, 0, 4};
        tbl[8]  = '{0, 16'h6666, 1,  16'h6666, 0, 4};
        tbl[9]  = '{0, 16'h7777, 1,  16'h7777, 0, 4};
        tbl[10] = '{0, 16'h8888, 1,  16'h8888, 0, 4};
        tbl[11] = '{1, 16'h0,    0,  16'h7777, 1, 4};
        tbl[12] = '{1, 16'h0,    0,  16'h6666, 2, 4};
        tbl[13] = '{1, 16'h0,    0,  16'h5555, 3, 4};
        tbl[14] = '{1, 16'h0,    0,  16'h8888, 0, 4};

        // Test 1: reset state, idle, and presses while empty
        repeat (3) @(negedge clk);
        chk_all("t1.in_reset", 16'h0, 0, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk_all("t1.idle", 16'h0, 0, 0);
        press();
        press();
        chk_all("t1.step_empty", 16'h0, 0, 0);

        // Tests 2-4: captures, paging, hold-once, overwrite when full
        foreach (tbl[i]) begin
            if (tbl[i].op == 0) do_load(tbl[i].d, tbl[i].hold);
            else press();
            chk_all($sformatf("tbl[%0d]", i), tbl[i].e_dout, tbl[i].e_idx, tbl[i].e_cnt);
        end

        // Test 5: 1-0-1 bounce at 2-cycle spacing then steady; step lands on the
        // seventh edge after steady high (2 sync + 4 debounce + 1 pulse)
        step_key = 1'b1; repeat (2) @(negedge clk);
        step_key = 1'b0; repeat (2) @(negedge clk);
        step_key = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5.before_pulse.idx", 32'(idx), 0);
        @(negedge clk);
        chk("t5.at_pulse.idx", 32'(idx), 1);
        repeat (10) @(negedge clk);
        chk_all("t5.held", 16'h7777, 1, 4);
        step_key = 1'b0;
        repeat (10) @(negedge clk);
        chk_all("t5.release", 16'h7777, 1, 4);

        // Test 6a: capture and step land on the same edge -> capture wins
        step_key = 1'b1;
        repeat (6) @(negedge clk);
        din  = 16'h9999;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk_all("t6.cap_vs_step", 16'h9999, 0, 4);
        step_key = 1'b0;
        repeat (10) @(negedge clk);
        chk_all("t6.after_release", 16'h9999, 0, 4);

        // Test 6b: async reset mid-debounce with the key held
        step_key = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all("t6.async_reset", 16'h0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_load(16'hAAAA, 1);
        do_load(16'hBBBB, 1);
        repeat (20) @(negedge clk);
        chk_all("t6.held_after_reset", 16'hBBBB, 0, 2);
        step_key = 1'b0;
        repeat (10) @(negedge clk);
        chk_all("t6.released", 16'hBBBB, 0, 2);
        press();
        chk_all("t6.repress", 16'hAAAA, 1, 2);

        // Random phase against a queue model of the history
        do_reset();
        chk_all("rnd.reset", 16'h0, 0, 0);
        midx = 0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                rd = 16'($urandom_range(0, 65535));
                do_load(rd, 1 + int'($urandom_range(0, 2)));
                q.push_back(int'(rd));
                if (q.size() > DEPTH) void'(q.pop_front());
                midx = 0;
            end else begin
                press();
                if (q.size() > 0) midx = (midx == q.size() - 1) ? 0 : midx + 1;
            end
            exp_d = (q.size() == 0) ? 16'h0 : 16'(q[q.size() - 1 - midx]);
            chk_all($sformatf("rnd[%0d]", n), exp_d, midx, q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
